// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the pixel-width LFSR: loads seed/stop through the config handshake,
// verifies each readback, then supervises the run until lfsr_done or timeout.
module lfsr_seq_ctrl #(
    parameter int MAX_PIXEL_BITS = 8,
    parameter int CFG_WAIT_MAX   = 4,
    parameter int RUN_TIMEOUT    = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [MAX_PIXEL_BITS-1:0] seed_i,
    input  logic [MAX_PIXEL_BITS-1:0] stop_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [CNT_W-1:0]          run_cycles_o,
    output logic                      lfsr_config_o,
    output logic                      lfsr_config_rdy_o,
    output logic [MAX_PIXEL_BITS-1:0] lfsr_config_data_o,
    input  logic [MAX_PIXEL_BITS-1:0] lfsr_config_data_i,
    input  logic                      lfsr_config_done_i,
    input  logic                      lfsr_done_i,
    output logic                      lfsr_run_o
);

    localparam int WAIT_W = $clog2(CFG_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CFG_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  RUN_LIMIT = CNT_W'(RUN_TIMEOUT);

    localparam logic [1:0] CODE_SEED_ZERO = 2'b01;
    localparam logic [1:0] CODE_MISMATCH  = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT   = 2'b11;

    typedef enum logic [2:0] {
        IDLE, LOAD_SEED, WAIT_SEED, LOAD_STOP, WAIT_STOP, RUN, DONE, ERR
    } state_t;

    state_t                    state;
    logic [MAX_PIXEL_BITS-1:0] seed;
    logic [MAX_PIXEL_BITS-1:0] stop;
    logic [WAIT_W-1:0]         wait_cnt;
    logic [CNT_W-1:0]          run_inc;

    // run_cycles_o doubles as the live run counter; it saturates rather than wraps
    always_comb begin
        run_inc = (&run_cycles_o) ? run_cycles_o : run_cycles_o + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state              <= IDLE;
            seed               <= '0;
            stop               <= '0;
            wait_cnt           <= '0;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            err_o              <= 1'b0;
            err_code_o         <= 2'b00;
            run_cycles_o       <= '0;
            lfsr_config_o      <= 1'b0;
            lfsr_config_rdy_o  <= 1'b0;
            lfsr_config_data_o <= '0;
            lfsr_run_o         <= 1'b0;
        end else begin
            lfsr_config_rdy_o <= 1'b0;
            done_o            <= 1'b0;
            if (abort_i && state != IDLE) begin
                state         <= IDLE;
                busy_o        <= 1'b0;
                lfsr_run_o    <= 1'b0;
                lfsr_config_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            seed         <= seed_i;
                            stop         <= stop_i;
                            err_o        <= 1'b0;
                            err_code_o   <= 2'b00;
                            run_cycles_o <= '0;
                            busy_o       <= 1'b1;
                            if (seed_i == '0) begin
                                state      <= ERR;
                                err_o      <= 1'b1;
                                err_code_o <= CODE_SEED_ZERO;
                            end else begin
                                state              <= LOAD_SEED;
                                lfsr_config_rdy_o  <= 1'b1;
                                lfsr_config_o      <= 1'b0;
                                lfsr_config_data_o <= seed_i;
                            end
                        end
                    end
                    LOAD_SEED: begin
                        state    <= WAIT_SEED;
                        wait_cnt <= '0;
                    end
                    WAIT_SEED: begin
                        if (lfsr_config_done_i) begin
                            if (lfsr_config_data_i == seed) begin
                                state              <= LOAD_STOP;
                                lfsr_config_rdy_o  <= 1'b1;
                                lfsr_config_o      <= 1'b1;
                                lfsr_config_data_o <= stop;
                            end else begin
                                state      <= ERR;
                                err_o      <= 1'b1;
                                err_code_o <= CODE_MISMATCH;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            state      <= ERR;
                            err_o      <= 1'b1;
                            err_code_o <= CODE_TIMEOUT;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    LOAD_STOP: begin
                        state    <= WAIT_STOP;
                        wait_cnt <= '0;
                    end
                    WAIT_STOP: begin
                        if (lfsr_config_done_i) begin
                            lfsr_config_o <= 1'b0;
                            if (lfsr_config_data_i == stop) begin
                                state      <= RUN;
                                lfsr_run_o <= 1'b1;
                            end else begin
                                state      <= ERR;
                                err_o      <= 1'b1;
                                err_code_o <= CODE_MISMATCH;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            state         <= ERR;
                            lfsr_config_o <= 1'b0;
                            err_o         <= 1'b1;
                            err_code_o    <= CODE_TIMEOUT;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        run_cycles_o <= run_inc;
                        if (lfsr_done_i) begin
                            state      <= DONE;
                            lfsr_run_o <= 1'b0;
                            done_o     <= 1'b1;
                        end else if (run_inc >= RUN_LIMIT) begin
                            state      <= ERR;
                            lfsr_run_o <= 1'b0;
                            err_o      <= 1'b1;
                            err_code_o <= CODE_TIMEOUT;
                        end
                    end
                    DONE, ERR: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        lfsr_run_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl; a second instance with RUN_TIMEOUT=8 covers the run timeout.
module tb_lfsr_seq_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, start, abort, cfg_done, lfsr_done;
    logic [W-1:0]     seed, stop, rback;

    logic             busy, done, err, cfg_sel, cfg_rdy, run;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] run_cycles;
    logic [W-1:0]     cfg_data;

    logic             busy_to, done_to, err_to, cfg_sel_to, cfg_rdy_to, run_to;
    logic [1:0]       err_code_to;
    logic [CNT_W-1:0] run_cycles_to;
    logic [W-1:0]     cfg_data_to;

    lfsr_seq_ctrl #(.MAX_PIXEL_BITS(W), .CFG_WAIT_MAX(4), .RUN_TIMEOUT(16), .CNT_W(CNT_W)) u_dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .seed_i(seed), .stop_i(stop),
        .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code),
        .run_cycles_o(run_cycles),
        .lfsr_config_o(cfg_sel), .lfsr_config_rdy_o(cfg_rdy), .lfsr_config_data_o(cfg_data),
        .lfsr_config_data_i(rback), .lfsr_config_done_i(cfg_done), .lfsr_done_i(lfsr_done),
        .lfsr_run_o(run)
    );

    lfsr_seq_ctrl #(.MAX_PIXEL_BITS(W), .CFG_WAIT_MAX(4), .RUN_TIMEOUT(8), .CNT_W(CNT_W)) u_dut_to (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .seed_i(seed), .stop_i(stop),
        .busy_o(busy_to), .done_o(done_to), .err_o(err_to), .err_code_o(err_code_to),
        .run_cycles_o(run_cycles_to),
        .lfsr_config_o(cfg_sel_to), .lfsr_config_rdy_o(cfg_rdy_to), .lfsr_config_data_o(cfg_data_to),
        .lfsr_config_data_i(rback), .lfsr_config_done_i(cfg_done), .lfsr_done_i(lfsr_done),
        .lfsr_run_o(run_to)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Entered at the negedge of start cycle t; returns at the negedge of t+5.
    task automatic load_phase(input logic [W-1:0] s, input logic [W-1:0] p,
                              input logic [W-1:0] p_rb, input bit poke);
        seed  = s;
        stop  = p;
        start = 1'b1;
        tick();                                    // t+1: LOAD_SEED
        start = 1'b0;
        chk("ld_err_clear", err, 0);
        chk("ld_rdy_seed", cfg_rdy, 1);
        chk("ld_sel_seed", cfg_sel, 0);
        chk("ld_data_seed", cfg_data, s);
        tick();                                    // t+2: WAIT_SEED
        chk("ld_rdy_low", cfg_rdy, 0);
        cfg_done = 1'b1;
        rback    = s;
        if (poke) begin
            start = 1'b1;
            seed  = ~s;
            stop  = ~p;
        end
        tick();                                    // t+3: LOAD_STOP
        start    = 1'b0;
        seed     = s;
        stop     = p;
        cfg_done = 1'b0;
        chk("ld_rdy_stop", cfg_rdy, 1);
        chk("ld_sel_stop", cfg_sel, 1);
        chk("ld_data_stop", cfg_data, p);
        tick();                                    // t+4: WAIT_STOP
        chk("ld_run_low", run, 0);
        cfg_done = 1'b1;
        rback    = p_rb;
        tick();                                    // t+5
        cfg_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_done = 1'b0; lfsr_done = 1'b0;
        seed = '0; stop = '0; rback = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_cycles", run_cycles, 0);
        chk("rst_rdy", cfg_rdy, 0);
        chk("rst_sel", cfg_sel, 0);
        chk("rst_data", cfg_data, 0);
        chk("rst_run", run, 0);
        reset = 1'b0;
        tick();

        // Zero seed: straight to ERR for one cycle
        seed = 8'h00; stop = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zs_busy", busy, 1);
        chk("zs_err", err, 1);
        chk("zs_code", err_code, 2'b01);
        chk("zs_rdy", cfg_rdy, 0);
        tick();
        chk("zs_busy_off", busy, 0);
        chk("zs_err_sticky", err, 1);
        chk("zs_rdy2", cfg_rdy, 0);
        tick();

        // Stop readback mismatch (also clears the sticky error on start)
        load_phase(8'h11, 8'h3C, 8'h3D, 1'b0);
        chk("mm_err", err, 1);
        chk("mm_code", err_code, 2'b10);
        chk("mm_run", run, 0);
        chk("mm_busy", busy, 1);
        tick();
        chk("mm_run2", run, 0);
        chk("mm_busy_off", busy, 0);
        tick();

        // Config-done never arrives: timeout after 4 WAIT_SEED cycles
        seed = 8'h01; stop = 8'h02; start = 1'b1;
        tick();                                    // t+1
        start = 1'b0;
        chk("ct_err_clear", err, 0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("ct_wait_busy", busy, 1);
            chk("ct_wait_err", err, 0);
        end
        tick();                                    // t+6: ERR
        chk("ct_err", err, 1);
        chk("ct_code", err_code, 2'b11);
        tick();
        chk("ct_busy_off", busy, 0);
        tick();

        // Start during WAIT_SEED is ignored; one-cycle run gives 6-cycle latency
        load_phase(8'h5A, 8'hC3, 8'hC3, 1'b1);
        chk("sb_run", run, 1);
        chk("sb_err", err, 0);
        lfsr_done = 1'b1;
        tick();                                    // t+6
        lfsr_done = 1'b0;
        chk("sb_done", done, 1);
        chk("sb_cycles", run_cycles, 1);
        chk("sb_run_off", run, 0);
        tick();
        chk("sb_done_pulse", done, 0);
        chk("sb_busy_off", busy, 0);
        tick();

        // Nominal 10-cycle run; u_dut_to times out after 8 RUN cycles
        load_phase(8'hA5, 8'h3C, 8'h3C, 1'b0);     // now at t+5, RUN cycle 1
        chk("nm_run", run, 1);
        chk("nm_cycles0", run_cycles, 0);
        for (int i = 2; i <= 10; i++) begin
            tick();                                // RUN cycle i of u_dut
            chk("nm_no_done", done, 0);
            if (i == 9) begin
                chk("to_err", err_to, 1);
                chk("to_code", err_code_to, 2'b11);
                chk("to_cycles", run_cycles_to, 8);
                chk("to_run", run_to, 0);
            end
            if (i == 10) begin
                chk("to_busy_off", busy_to, 0);
                lfsr_done = 1'b1;
            end
        end
        tick();                                    // t+15
        lfsr_done = 1'b0;
        chk("nm_done", done, 1);
        chk("nm_cycles", run_cycles, 10);
        chk("nm_err", err, 0);
        chk("nm_run_off", run, 0);
        chk("to_no_done", done_to, 0);
        chk("to_err_sticky", err_to, 1);
        tick();
        chk("nm_done_pulse", done, 0);
        chk("nm_busy_off", busy, 0);
        chk("nm_cycles_held", run_cycles, 10);
        tick();

        // Abort in RUN cycle 3
        load_phase(8'h81, 8'h18, 8'h18, 1'b0);
        tick();
        tick();                                    // RUN cycle 3
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_run", run, 0);
        chk("ab_done", done, 0);
        chk("ab_err", err, 0);
        chk("ab_cycles", run_cycles, 2);
        tick();
        chk("ab_done2", done, 0);
        load_phase(8'h42, 8'h24, 8'h24, 1'b0);
        chk("ab_rerun", run, 1);
        tick();
        tick();                                    // RUN cycle 3
        lfsr_done = 1'b1;
        tick();
        lfsr_done = 1'b0;
        chk("ab_re_done", done, 1);
        chk("ab_re_cycles", run_cycles, 3);
        tick();

        // Asynchronous reset mid-RUN, between clock edges
        load_phase(8'h99, 8'h66, 8'h66, 1'b0);
        tick();
        chk("ar_run_pre", run, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_run", run, 0);
        chk("ar_busy", busy, 0);
        chk("ar_rdy", cfg_rdy, 0);
        chk("ar_cycles", run_cycles, 0);
        chk("ar_data", cfg_data, 0);
        #1 reset = 1'b0;
        tick();
        chk("ar_idle_busy", busy, 0);
        chk("ar_idle_run", run, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencer for the pixel-width LFSR block in the grayscale/Sobel datapath. On a host start request it captures seed and stop values and loads both into the LFSR through its config_i/config_rdy_i handshake. It reads each value back and checks it, then enables the LFSR and supervises the run until lfsr_done, counting run cycles. It reports completion, errors and timeouts to the host.

## Interface
- MAX_PIXEL_BITS, 8, width of seed/stop/LFSR data
- CFG_WAIT_MAX, 4, cycles allowed for config_done after a config_rdy pulse (≥1)
- RUN_TIMEOUT, 1024, max RUN cycles before timeout (≥2)
- CNT_W, 16, width of run-cycle counter
- clk_i  in  1  clock; all logic on rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  host start request; sampled only in IDLE
- abort_i  in  1  synchronous abort; highest priority after reset
- seed_i  in  MAX_PIXEL_BITS  seed value, captured at start
- stop_i  in  MAX_PIXEL_BITS  stop value, captured at start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on successful run completion
- err_o  out  1  sticky error flag
- err_code_o  out  2  01 seed zero, 10 readback mismatch, 11 timeout; 00 none
- run_cycles_o  out  CNT_W  RUN-cycle count of last run; held until next start
- lfsr_config_o  out  1  to LFSR config_i: 0 = seed, 1 = stop
- lfsr_config_rdy_o  out  1  to LFSR config_rdy_i, one-cycle pulse
- lfsr_config_data_o  out  MAX_PIXEL_BITS  to LFSR config_data_i
- lfsr_config_data_i  in  MAX_PIXEL_BITS  from LFSR config_data_o (readback)
- lfsr_config_done_i  in  1  from LFSR config_done_o
- lfsr_done_i  in  1  from LFSR lfsr_done
- lfsr_run_o  out  1  enable to LFSR stepping; high only in RUN

## Operation
- FSM states: IDLE, LOAD_SEED, WAIT_SEED, LOAD_STOP, WAIT_STOP, RUN, DONE, ERR.
- All outputs are registered and decoded from the current state and registers.
- IDLE & start_i:
  - Capture seed_i/stop_i into shadow registers.
  - Clear err_o, err_code_o and run_cycles_o.
  - If seed_i == 0, go to ERR with code 01. Otherwise go to LOAD_SEED.
- LOAD_SEED (1 cycle):
  - lfsr_config_rdy_o=1, lfsr_config_o=0, lfsr_config_data_o=seed.
  - Go to WAIT_SEED.
- WAIT_SEED:
  - lfsr_config_o is held at 0 and the wait counter increments.
  - When lfsr_config_done_i=1, compare lfsr_config_data_i with seed. On match go to LOAD_STOP; on mismatch go to ERR with code 10.
  - If the counter reaches CFG_WAIT_MAX without config_done, go to ERR with code 11.
- LOAD_STOP/WAIT_STOP: same as the seed states, with lfsr_config_o=1 and stop as the data. On match go to RUN.
- RUN:
  - lfsr_run_o=1; run counter increments each cycle, saturating at all-ones.
  - lfsr_done_i=1 → DONE. run_cycles_o = count including the done cycle.
  - Counter reaching RUN_TIMEOUT without done → ERR with code 11.
- DONE (1 cycle): done_o=1, then go to IDLE.
- ERR (1 cycle): err_o/err_code_o are set on entry, then go to IDLE. err_o stays high until the next accepted start.
- abort_i in any non-IDLE state:
  - Go to IDLE next cycle and deassert lfsr_run_o/lfsr_config_rdy_o.
  - err_o, err_code_o and run_cycles_o are unchanged; no done_o.
- Reset values:
  - State IDLE, every output 0, shadow registers 0, counters 0.
- start_i while busy is ignored. lfsr_done_i outside RUN is ignored.
- abort_i and start_i together in IDLE: start wins (abort is only meaningful when busy).

## Timing
- Cycle t: IDLE sees start_i.
- t+1: LOAD_SEED, rdy pulse.
- t+2: WAIT_SEED. With the nominal LFSR, config_done=1 here and the compare happens this cycle.
- t+3: LOAD_STOP.
- t+4: WAIT_STOP.
- t+5: first RUN cycle; lfsr_run_o rises.
- lfsr_done_i seen at cycle r → DONE at r+1 (done_o pulse) → IDLE at r+2.
- Minimum start-to-done_o latency: 6 cycles for a 1-cycle run.
- Reset asserted mid-operation clears everything asynchronously. lfsr_config_rdy_o and lfsr_run_o drop immediately, with no glitch on deassertion.

## Test plan
- Nominal run:
  - Stimulus: seed=0xA5, stop=0x3C; model LFSR returns matching readback at t+2/t+4 and lfsr_done 10 cycles into RUN.
  - Required: rdy pulses at t+1 (sel 0, data 0xA5) and t+3 (sel 1, data 0x3C); done_o at t+15; run_cycles_o=10; err_o=0.
- Zero seed:
  - Stimulus: seed=0x00.
  - Required: no rdy pulse; err_o=1, err_code_o=01 one cycle after start; busy_o high for exactly one cycle.
- Readback mismatch:
  - Stimulus: model returns 0x3D for stop=0x3C.
  - Required: ERR with code 10; lfsr_run_o never asserts.
- Timeouts:
  - Stimulus: config_done held low, with CFG_WAIT_MAX=4.
  - Required: code 11 after 4 WAIT cycles. Separately, lfsr_done never arrives with RUN_TIMEOUT=8 → code 11 after 8 RUN cycles.
- Abort and reset:
  - Stimulus: abort_i in RUN cycle 3.
  - Required: IDLE next cycle, no done_o, err_o=0; a new start then works nominally.
  - Stimulus: reset_i pulsed mid-RUN (asynchronous, not on a clock edge).
  - Required: all outputs 0 immediately.
- Start while busy and sticky clear:
  - Stimulus: start_i pulses during WAIT_SEED.
  - Required: ignored.
  - Stimulus: after an error, a valid start.
  - Required: err_o clears on the start cycle edge.
